// File: rtl/axi4_rd_arbiter.sv
// ============================================================================
// Module   : axi4_rd_arbiter
// Purpose  : Round-robin sharing of one AXI4 read subordinate among NUM_M
//            managers, one burst in flight, with returned-length checking.
// Revision : 1.0
// ============================================================================
`default_nettype none

module axi4_rd_arbiter #(
    parameter int NUM_M  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic [NUM_M*ID_W-1:0]     m_arid,
    input  logic [NUM_M*ADDR_W-1:0]   m_araddr,
    input  logic [NUM_M*8-1:0]        m_arlen,
    input  logic [NUM_M*3-1:0]        m_arsize,
    input  logic [NUM_M*2-1:0]        m_arburst,
    input  logic [NUM_M-1:0]          m_arvalid,
    output logic [NUM_M-1:0]          m_arready,
    output logic [NUM_M*ID_W-1:0]     m_rid,
    output logic [NUM_M*DATA_W-1:0]   m_rdata,
    output logic [NUM_M*2-1:0]        m_rresp,
    output logic [NUM_M-1:0]          m_rlast,
    output logic [NUM_M-1:0]          m_rvalid,
    input  logic [NUM_M-1:0]          m_rready,
    output logic [ID_W-1:0]           s_arid,
    output logic [ADDR_W-1:0]         s_araddr,
    output logic [7:0]                s_arlen,
    output logic [2:0]                s_arsize,
    output logic [1:0]                s_arburst,
    output logic                      s_arvalid,
    input  logic                      s_arready,
    input  logic [ID_W-1:0]           s_rid,
    input  logic [DATA_W-1:0]         s_rdata,
    input  logic [1:0]                s_rresp,
    input  logic                      s_rlast,
    input  logic                      s_rvalid,
    output logic                      s_rready,
    output logic [$clog2(NUM_M)-1:0]  grant_idx,
    output logic                      busy,
    output logic                      len_err
);

    localparam int GW = $clog2(NUM_M);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t          state;
    logic [GW-1:0]   last;
    logic [7:0]      beat_cnt;
    logic [7:0]      exp_len;
    logic [ID_W-1:0] ar_id;
    logic [ADDR_W-1:0] ar_addr;
    logic [2:0]      ar_size;
    logic [1:0]      ar_burst;

    logic [GW-1:0]   pick;
    logic            found;
    logic            r_hs;
    int              idx;

    // Search starts just after the last completed grant, wrapping modulo NUM_M.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NUM_M; k++) begin
            idx = (int'(last) + k) % NUM_M;
            if (!found && m_arvalid[GW'(idx)]) begin
                found = 1'b1;
                pick  = GW'(idx);
            end
        end
    end

    assign s_arvalid = (state == S_ADDR);
    assign s_arid    = ar_id;
    assign s_araddr  = ar_addr;
    assign s_arlen   = exp_len;
    assign s_arsize  = ar_size;
    assign s_arburst = ar_burst;
    assign s_rready  = (state == S_DATA) && m_rready[grant_idx];
    assign busy      = (state != S_IDLE);
    assign r_hs      = (state == S_DATA) && s_rvalid && s_rready;

    always_comb begin
        m_arready = '0;
        m_rvalid  = '0;
        m_rlast   = '0;
        if (state == S_ADDR) begin
            m_arready[grant_idx] = s_arready;
        end
        if (state == S_DATA) begin
            m_rvalid[grant_idx] = s_rvalid;
            m_rlast[grant_idx]  = s_rlast;
        end
    end

    // R payload is broadcast; only the granted manager sees valid/last.
    for (genvar i = 0; i < NUM_M; i++) begin : g_rfan
        assign m_rid[i*ID_W +: ID_W]       = s_rid;
        assign m_rdata[i*DATA_W +: DATA_W] = s_rdata;
        assign m_rresp[i*2 +: 2]           = s_rresp;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state     <= S_IDLE;
            grant_idx <= '0;
            last      <= GW'(NUM_M - 1);
            beat_cnt  <= '0;
            len_err   <= 1'b0;
            exp_len   <= '0;
            ar_id     <= '0;
            ar_addr   <= '0;
            ar_size   <= '0;
            ar_burst  <= '0;
        end else begin
            len_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        grant_idx <= pick;
                        ar_id     <= m_arid[pick*ID_W +: ID_W];
                        ar_addr   <= m_araddr[pick*ADDR_W +: ADDR_W];
                        exp_len   <= m_arlen[pick*8 +: 8];
                        ar_size   <= m_arsize[pick*3 +: 3];
                        ar_burst  <= m_arburst[pick*2 +: 2];
                        state     <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (s_arready) begin
                        beat_cnt <= '0;
                        state    <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (r_hs) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        if (s_rlast) begin
                            len_err <= (beat_cnt != exp_len);
                            last    <= grant_idx;
                            state   <= S_IDLE;
                        end else if (beat_cnt == exp_len) begin
                            // Overlong burst: flag it, keep draining until RLAST.
                            len_err <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
